// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues in-order word fetches, buffers returned instructions, handles redirects.
// Latency: a response in cycle N is offered to decode in cycle N+1 (same cycle when FETCH_BYPASS_EN is defined).
// Backpressure: decode stalls via io_out_ready; requests are withheld while in-flight plus buffered reaches FIFO_DEPTH.
// Ports: clock/reset (sync, active-high); io_imem_req_* fetch requests; io_imem_resp_* in-order responses (never stalled);
//        io_redirect_* new PC from branch/jump resolution; io_out_* instruction, PC and pre-sliced fields to decode.
// Optional feature: define FETCH_BYPASS_EN to forward a response straight to io_out_* when the buffer is empty.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        io_imem_req_valid,
    input  logic        io_imem_req_ready,
    output logic [31:0] io_imem_req_addr,
    input  logic        io_imem_resp_valid,
    input  logic [31:0] io_imem_resp_data,
    input  logic        io_redirect_valid,
    input  logic [31:0] io_redirect_pc,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [31:0] io_out_inst,
    output logic [31:0] io_out_pc,
    output logic [6:0]  io_out_opcode,
    output logic [2:0]  io_out_funct3,
    output logic [6:0]  io_out_funct7
);
    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam int              CNT_W    = PTR_W + 1;
    localparam logic [CNT_W:0]  DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [31:0]     NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      buf_inst_q [FIFO_DEPTH];
    logic [31:0]      buf_pc_q   [FIFO_DEPTH];

    logic             fifo_empty;
    logic             resp_fire;
    logic             redir;
    logic             req_fire;
    logic             push;
    logic             pop;
    logic             byp_vld;
    logic [CNT_W:0]   inflight;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] resp_dec;
    logic             unused_redirect_lsb;

    // The low address bits of a redirect target are always forced to zero.
    assign unused_redirect_lsb = ^io_redirect_pc[1:0];

    assign fifo_empty = (cnt_q == '0);
    // A response with nothing outstanding is stale (e.g. issued before reset) and is ignored.
    assign resp_fire  = io_imem_resp_valid && (outst_q != '0);
    assign redir      = io_redirect_valid && (state_q != BOOT);
    assign resp_dec   = CNT_W'(resp_fire);

    assign inflight          = {1'b0, outst_q} + {1'b0, cnt_q};
    assign io_imem_req_valid = (state_q == FETCH) && !io_redirect_valid && (inflight < DEPTH_C);
    assign io_imem_req_addr  = pc_q;
    assign req_fire          = io_imem_req_valid && io_imem_req_ready;

    // Responses return in request order, so the oldest in-flight fetch sits outst_q words behind pc_q.
    assign resp_pc = pc_q - {{(30 - CNT_W){1'b0}}, outst_q, 2'b00};

`ifdef FETCH_BYPASS_EN
    assign byp_vld = (state_q == FETCH) && fifo_empty && resp_fire && !io_redirect_valid;
`else
    assign byp_vld = 1'b0;
`endif

    assign io_out_valid = (!fifo_empty || byp_vld) && !io_redirect_valid;
    assign pop          = io_out_valid && io_out_ready && !fifo_empty;
    // A bypassed response consumed the same cycle never needs a buffer slot.
    assign push         = (state_q == FETCH) && !redir && resp_fire && !(byp_vld && io_out_ready);

    always_comb begin
        io_out_inst = NOP_INST;
        io_out_pc   = RESET_PC;
        if (!fifo_empty) begin
            io_out_inst = buf_inst_q[rd_ptr_q];
            io_out_pc   = buf_pc_q[rd_ptr_q];
        end else if (byp_vld) begin
            io_out_inst = io_imem_resp_data;
            io_out_pc   = resp_pc;
        end
    end

    assign io_out_opcode = io_out_inst[6:0];
    assign io_out_funct3 = io_out_inst[14:12];
    assign io_out_funct7 = io_out_inst[31:25];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        outst_d  = outst_q;
        drop_d   = drop_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        case (state_q)
            BOOT: state_d = FETCH;
            FETCH, DRAIN: begin
                if (redir) begin
                    pc_d     = {io_redirect_pc[31:2], 2'b00};
                    cnt_d    = '0;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    // A response landing in the redirect cycle is already wrong-path and retires now.
                    outst_d  = outst_q - resp_dec;
                    drop_d   = outst_q - resp_dec;
                    state_d  = ((outst_q - resp_dec) != '0) ? DRAIN : FETCH;
                end else if (state_q == FETCH) begin
                    if (req_fire) begin
                        pc_d = pc_q + 32'd4;
                    end
                    outst_d = outst_q + CNT_W'(req_fire) - resp_dec;
                    cnt_d   = cnt_q + CNT_W'(push) - CNT_W'(pop);
                    if (push) begin
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    end
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                end else begin
                    // Wrong-path responses are dropped until every pre-redirect fetch has returned.
                    outst_d = outst_q - resp_dec;
                    drop_d  = drop_q - resp_dec;
                    if ((drop_q - resp_dec) == '0) begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_inst_q[i] <= NOP_INST;
                buf_pc_q[i]   <= RESET_PC;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (push) begin
                buf_inst_q[wr_ptr_q] <= io_imem_resp_data;
                buf_pc_q[wr_ptr_q]   <= resp_pc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: in-order memory model with epoch-tagged requests,
// expected-instruction queue filled by the memory model, output monitor that drains it.
module tb_fetch_stage;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_imem_req_valid;
    logic        io_imem_req_ready = 1'b0;
    logic [31:0] io_imem_req_addr;
    logic        io_imem_resp_valid = 1'b0;
    logic [31:0] io_imem_resp_data = 32'h0;
    logic        io_redirect_valid = 1'b0;
    logic [31:0] io_redirect_pc = 32'h0;
    logic        io_out_valid;
    logic        io_out_ready = 1'b0;
    logic [31:0] io_out_inst;
    logic [31:0] io_out_pc;
    logic [6:0]  io_out_opcode;
    logic [2:0]  io_out_funct3;
    logic [6:0]  io_out_funct7;

    always #5 clock = ~clock;

    fetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clock             (clock),
        .reset             (reset),
        .io_imem_req_valid (io_imem_req_valid),
        .io_imem_req_ready (io_imem_req_ready),
        .io_imem_req_addr  (io_imem_req_addr),
        .io_imem_resp_valid(io_imem_resp_valid),
        .io_imem_resp_data (io_imem_resp_data),
        .io_redirect_valid (io_redirect_valid),
        .io_redirect_pc    (io_redirect_pc),
        .io_out_valid      (io_out_valid),
        .io_out_ready      (io_out_ready),
        .io_out_inst       (io_out_inst),
        .io_out_pc         (io_out_pc),
        .io_out_opcode     (io_out_opcode),
        .io_out_funct3     (io_out_funct3),
        .io_out_funct7     (io_out_funct7)
    );

    typedef struct packed { logic [31:0] pc; logic [31:0] inst; } exp_t;
    typedef struct packed { logic [31:0] addr; logic [15:0] epoch; } flight_t;

    exp_t        sb_q[$];      // instructions decode should still receive, oldest first
    flight_t     fl_q[$];      // requests accepted by memory, not yet answered
    logic [15:0] epoch = 16'd0;
    logic [31:0] exp_fetch = RST_PC;
    bit          booting = 1'b1;
    bit          sb_en = 1'b0;
    int          sb_occ = 0;
    int          tests = 0;
    int          fails = 0;
    int          p_rdy = 0, p_resp = 0, p_ordy = 0, p_redir = 0;
    bit          force_redir = 1'b0;
    bit          late_resp = 1'b0;
    logic [31:0] redir_target = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0050_0093;
    endfunction

    function automatic bit has_old();
        foreach (fl_q[i]) if (fl_q[i].epoch != epoch) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check request side at negedge, update the model after the edge.
    task automatic cycle();
        bit          s_fire, s_resp, s_redir, exp_rv;
        logic [31:0] s_addr, s_rpc;
        flight_t     f;
        io_imem_req_ready = ($urandom_range(99) < p_rdy);
        s_resp = 1'b0;
        if (late_resp) begin
            io_imem_resp_valid = 1'b1;
            io_imem_resp_data  = 32'h0000_0033;
        end else if (fl_q.size() != 0 && $urandom_range(99) < p_resp) begin
            io_imem_resp_valid = 1'b1;
            io_imem_resp_data  = mem_word(fl_q[0].addr);
            s_resp = 1'b1;
        end else begin
            io_imem_resp_valid = 1'b0;
            io_imem_resp_data  = $urandom;
        end
        io_out_ready      = ($urandom_range(99) < p_ordy);
        io_redirect_valid = force_redir || (!booting && $urandom_range(999) < p_redir);
        io_redirect_pc    = force_redir ? redir_target :
                            (($urandom_range(3) == 0) ? 32'hFFFF_FFF9 : $urandom);
        force_redir = 1'b0;
        late_resp   = 1'b0;
        @(negedge clock);
        exp_rv = !booting && !io_redirect_valid && !has_old() && (fl_q.size() + sb_occ < DEPTH);
        check("req_valid", 32'(io_imem_req_valid), 32'(exp_rv));
        s_fire  = io_imem_req_valid && io_imem_req_ready;
        s_addr  = io_imem_req_addr;
        s_redir = io_redirect_valid;
        s_rpc   = io_redirect_pc;
        @(posedge clock);
        #1;
        if (s_fire) begin
            check("req_addr", s_addr, exp_fetch);
            fl_q.push_back({s_addr, epoch});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (s_resp) begin
            f = fl_q.pop_front();
            if (!s_redir && f.epoch == epoch) sb_q.push_back({f.addr, mem_word(f.addr)});
        end
        if (s_redir) begin
            sb_q.delete();
            epoch     = epoch + 16'd1;
            exp_fetch = {s_rpc[31:2], 2'b00};
        end
        booting = 1'b0;
        sb_occ  = sb_q.size();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        io_imem_req_ready = 1'b0;
        io_imem_resp_valid = 1'b0;
        io_redirect_valid = 1'b0;
        io_out_ready = 1'b0;
        sb_en = 1'b0;
        repeat (n) @(posedge clock);
        @(negedge clock);
        check("rst_req_valid", 32'(io_imem_req_valid), 32'd0);
        check("rst_req_addr", io_imem_req_addr, RST_PC);
        check("rst_out_valid", 32'(io_out_valid), 32'd0);
        check("rst_out_inst", io_out_inst, 32'h0000_0013);
        check("rst_out_pc", io_out_pc, RST_PC);
        check("rst_opcode", 32'(io_out_opcode), 32'h13);
        check("rst_funct3", 32'(io_out_funct3), 32'd0);
        check("rst_funct7", 32'(io_out_funct7), 32'd0);
        @(posedge clock);
        #1;
        fl_q.delete();
        sb_q.delete();
        sb_occ    = 0;
        epoch     = epoch + 16'd1;
        exp_fetch = RST_PC;
        booting   = 1'b1;
        reset     = 1'b0;
        sb_en     = 1'b1;
    endtask

    // Let every request return and every buffered instruction leave.
    task automatic settle(input string name);
        bit ok = 1'b0;
        p_rdy = 0; p_resp = 100; p_ordy = 100; p_redir = 0;
        for (int i = 0; i < 40; i++) begin
            if (fl_q.size() == 0 && sb_occ == 0) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        check(name, 32'(ok), 32'd1);
    endtask

    // Issue requests without answering them until n are in flight.
    task automatic fill_flights(input int n, input string name);
        bit ok = 1'b0;
        p_rdy = 100; p_resp = 0; p_ordy = 100; p_redir = 0;
        for (int i = 0; i < 20; i++) begin
            if (fl_q.size() == n) begin
                ok = 1'b1;
                break;
            end
            cycle();
        end
        check(name, 32'(ok), 32'd1);
    endtask

    // Output monitor: decode must see exactly the queued instructions, in order.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb_en) begin
                check("out_valid", 32'(io_out_valid), 32'((sb_q.size() != 0) && !io_redirect_valid));
                if (io_out_valid && io_out_ready && sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("out_pc", io_out_pc, e.pc);
                    check("out_inst", io_out_inst, e.inst);
                    check("out_opcode", 32'(io_out_opcode), 32'(e.inst[6:0]));
                    check("out_funct3", 32'(io_out_funct3), 32'(e.inst[14:12]));
                    check("out_funct7", 32'(io_out_funct7), 32'(e.inst[31:25]));
                end
            end
        end
    end

    initial begin : stimulus
        do_reset(3);

        // Streaming from reset: memory always ready, single-cycle responses.
        p_rdy = 100; p_resp = 100; p_ordy = 100; p_redir = 0;
        repeat (20) cycle();

        // Decode stalls for 5 cycles, then drains.
        p_ordy = 0;
        repeat (5) cycle();
        p_ordy = 100;
        repeat (10) cycle();

        // Redirect to 0x103 with two requests in flight.
        settle("settle_a");
        fill_flights(2, "two_in_flight");
        redir_target = 32'h0000_0103; force_redir = 1'b1; p_resp = 0;
        cycle();
        p_resp = 100; p_rdy = 100;
        repeat (10) cycle();

        // Redirect in the same cycle as the only outstanding response.
        settle("settle_b");
        fill_flights(1, "one_in_flight");
        redir_target = 32'h0000_2000; force_redir = 1'b1; p_resp = 100; p_rdy = 100;
        cycle();
        repeat (8) cycle();

        // Reset while draining with one wrong-path response still pending.
        settle("settle_c");
        fill_flights(2, "two_in_flight_rst");
        redir_target = 32'h0000_0400; force_redir = 1'b1; p_resp = 0;
        cycle();
        p_resp = 100; p_rdy = 0;
        cycle();
        do_reset(2);
        late_resp = 1'b1; p_rdy = 100; p_resp = 100; p_ordy = 100;
        repeat (10) cycle();

        // Randomised traffic with occasional redirects, including near the address wrap.
        p_rdy = 70; p_resp = 60; p_ordy = 60; p_redir = 30;
        repeat (3000) cycle();

        settle("settle_final");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
